// File: rtl/key_conditioner.sv
// key_conditioner: per-channel synchroniser and debouncer for mechanical keys, with
// one-cycle press/release pulses and optional auto-repeat on held keys.
module key_conditioner #(
    parameter int N_KEYS          = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_press,
    output logic [N_KEYS-1:0] key_release,
    output logic              key_any
);

    localparam int            CW           = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST     = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic          RAW_RELEASED = (ACTIVE_LOW != 0);

    genvar g;
    generate
        for (g = 0; g < N_KEYS; g++) begin : g_key
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CW-1:0]          r_cnt;
            logic                   r_level;
            logic                   r_press;
            logic                   r_release;
            logic                   w_pressed;
            logic                   w_differs;
            logic                   w_toggle;
            logic                   w_repeat;

            // XOR with the released level turns the raw pin into 1 = pressed.
            assign w_pressed = r_sync[SYNC_STAGES-1] ^ RAW_RELEASED;
            assign w_differs = w_pressed ^ r_level;
            assign w_toggle  = w_differs && (r_cnt == CNT_LAST);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_sync    <= {SYNC_STAGES{RAW_RELEASED}};
                    r_cnt     <= '0;
                    r_level   <= 1'b0;
                    r_press   <= 1'b0;
                    r_release <= 1'b0;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], key_raw[g]};
                    if (w_differs && !w_toggle) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= '0;
                    end
                    if (w_toggle) begin
                        r_level <= ~r_level;
                    end
                    r_press   <= (w_toggle && !r_level) || w_repeat;
                    r_release <= w_toggle && r_level;
                end
            end

            if (REPEAT_CYCLES > 0) begin : g_rep
                localparam int            RW       = $clog2(REPEAT_CYCLES + 1);
                localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
                logic [RW-1:0] r_rep;

                // A release edge wins over a repeat that would land in the same cycle.
                assign w_repeat = r_level && !w_toggle && (r_rep == REP_LAST);

                always_ff @(posedge clk or posedge rst) begin
                    if (rst) begin
                        r_rep <= '0;
                    end else if (!r_level || w_toggle || (r_rep == REP_LAST)) begin
                        r_rep <= '0;
                    end else begin
                        r_rep <= r_rep + 1'b1;
                    end
                end
            end else begin : g_norep
                assign w_repeat = 1'b0;
            end

            assign key_level[g]   = r_level;
            assign key_press[g]   = r_press;
            assign key_release[g] = r_release;
        end
    endgenerate

    assign key_any = |key_press;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: directed vector table, hand-written repeat/reset
// sequences and a randomized phase compared against a behavioural key model.
module tb_key_conditioner;
  localparam int DEB  = 4;
  localparam int REP1 = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_raw = 4'hF;
  logic [3:0] l0, p0, r0, l1, p1, r1;
  logic       a0, a1;

  always #5 clk = ~clk;

  key_conditioner #(.N_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
                    .REPEAT_CYCLES(0), .ACTIVE_LOW(1)) dut0 (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .key_level(l0), .key_press(p0), .key_release(r0), .key_any(a0));

  key_conditioner #(.N_KEYS(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(DEB),
                    .REPEAT_CYCLES(REP1), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst(rst), .key_raw(key_raw),
    .key_level(l1), .key_press(p1), .key_release(r1), .key_any(a1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a key is accepted once its synchronised value has disagreed
  // with the accepted level for DEB consecutive cycles; held keys repeat every
  // REP cycles counted from the last press pulse.
  logic [3:0] raw_hist[$];
  logic [3:0] m_s;
  logic [3:0] m_level[2];
  logic [3:0] m_press[2];
  logic [3:0] m_rel[2];
  int         m_run[2][4];
  int         m_since[2][4];

  always @(posedge clk) begin
    if (rst) begin
      raw_hist = {4'hF, 4'hF};
      for (int j = 0; j < 2; j++) begin
        m_level[j] = 4'h0; m_press[j] = 4'h0; m_rel[j] = 4'h0;
        for (int k = 0; k < 4; k++) begin m_run[j][k] = 0; m_since[j][k] = 0; end
      end
    end else begin
      m_s = ~raw_hist.pop_front();
      raw_hist.push_back(key_raw);
      for (int j = 0; j < 2; j++) begin
        m_press[j] = 4'h0; m_rel[j] = 4'h0;
        for (int k = 0; k < 4; k++) begin
          if (m_s[k] != m_level[j][k]) m_run[j][k]++;
          else m_run[j][k] = 0;
          if (m_run[j][k] == DEB) begin
            m_run[j][k] = 0;
            m_level[j][k] = ~m_level[j][k];
            m_since[j][k] = 0;
            if (m_level[j][k]) m_press[j][k] = 1'b1;
            else m_rel[j][k] = 1'b1;
          end else if (m_level[j][k] && j == 1) begin
            m_since[j][k]++;
            if (m_since[j][k] == REP1) begin
              m_press[j][k] = 1'b1;
              m_since[j][k] = 0;
            end
          end
        end
      end
    end
  end

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input int n, input logic r, input logic [3:0] raw,
                              input logic [3:0] lv, input logic [3:0] pr, input logic [3:0] rl);
    vec_t v;
    v.rst = r; v.raw = raw; v.lvl = lv; v.prs = pr; v.rel = rl;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  int         press_e[$];
  int         rel_e;
  int         clash;
  int         seen;
  logic [3:0] raw_r;

  initial begin
    // reset, first cycles after deassert
    add(2, 1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
    add(3, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    // key 1 press then release, 6 edges each
    add(5, 1'b0, 4'hD, 4'h0, 4'h0, 4'h0);
    add(1, 1'b0, 4'hD, 4'h2, 4'h2, 4'h0);
    add(3, 1'b0, 4'hD, 4'h2, 4'h0, 4'h0);
    add(5, 1'b0, 4'hF, 4'h2, 4'h0, 4'h0);
    add(1, 1'b0, 4'hF, 4'h0, 4'h0, 4'h2);
    add(2, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    // 3-cycle glitch on key 0
    add(3, 1'b0, 4'hE, 4'h0, 4'h0, 4'h0);
    add(8, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    // all keys together
    add(5, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 1'b0, 4'h0, 4'hF, 4'hF, 4'h0);
    add(3, 1'b0, 4'h0, 4'hF, 4'h0, 4'h0);
    add(5, 1'b0, 4'hF, 4'hF, 4'h0, 4'h0);
    add(1, 1'b0, 4'hF, 4'h0, 4'h0, 4'hF);
    add(2, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst;
      key_raw = vecs[i].raw;
      @(posedge clk); #1;
      check($sformatf("vec%0d.level", i), 16'(l0), 16'(vecs[i].lvl));
      check($sformatf("vec%0d.press", i), 16'(p0), 16'(vecs[i].prs));
      check($sformatf("vec%0d.release", i), 16'(r0), 16'(vecs[i].rel));
      check($sformatf("vec%0d.any", i), 16'(a0), 16'(|vecs[i].prs));
    end

    // auto-repeat on key 2, raw low for 40 edges
    @(negedge clk); rst = 1'b1; key_raw = 4'hF;
    @(negedge clk); rst = 1'b0;
    rel_e = -1; clash = 0;
    for (int e = 1; e <= 60; e++) begin
      @(negedge clk);
      key_raw = (e <= 40) ? 4'hB : 4'hF;
      @(posedge clk); #1;
      if (p1[2]) press_e.push_back(e);
      if (r1[2]) rel_e = e;
      if (p1[2] && r1[2]) clash++;
    end
    check("rep.count", 16'(press_e.size()), 16'd4);
    for (int i = 0; i < 4 && i < press_e.size(); i++)
      check($sformatf("rep.press%0d", i), 16'(press_e[i]), 16'(6 + 10 * i));
    check("rep.release_edge", 16'(rel_e), 16'd46);
    check("rep.clash", 16'(clash), 16'd0);

    // key 3 held through a reset pulse
    @(negedge clk); key_raw = 4'h7;
    seen = 0;
    for (int c = 0; c < 20 && seen == 0; c++) begin
      @(posedge clk); #1;
      if (l0[3]) seen = 1;
    end
    check("hold.level_seen", 16'(seen), 16'd1);
    @(negedge clk); rst = 1'b1; #1;
    check("rst.async_out", {3'b0, l0, p0, r0, a0}, 16'h0);
    @(posedge clk); #1;
    check("rst.held_out", {3'b0, l0, p0, r0, a0}, 16'h0);
    @(negedge clk); rst = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      check($sformatf("rerst.press_e%0d", e), 16'(p0[3]), 16'(e == 6));
      check($sformatf("rerst.level_e%0d", e), 16'(l0[3]), 16'(e >= 6));
    end

    // randomized stimulus against the model
    @(negedge clk); rst = 1'b1; key_raw = 4'hF;
    raw_r = 4'hF;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++)
        if ($urandom_range(0, ((c % 300) < 150) ? 3 : 12) == 0) raw_r[k] = ~raw_r[k];
      key_raw = raw_r;
      rst = ($urandom_range(0, 299) == 0);
      @(posedge clk); #1;
      check("rnd.dut0", {3'b0, l0, p0, r0, a0},
            {3'b0, m_level[0], m_press[0], m_rel[0], |m_press[0]});
      check("rnd.dut1", {3'b0, l1, p1, r1, a1},
            {3'b0, m_level[1], m_press[1], m_rel[1], |m_press[1]});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1, "timeout");
  end
endmodule
